uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_if.sv | 36 +++
 rtl/uart_tx.sv | 134 +++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if -- handshake and serial-line bundle for the uart_tx transmitter.
//
// Signals:
//   tx_start  request to send tx_data (driven by master)
//   tx_data   byte to send, sampled only when a request is accepted (master)
//   txd       serial line, idle high (driven by slave)
//   tx_busy   high from acceptance until frame end (slave)
//   tx_done   one-cycle pulse at frame end (slave)
//
// Modports:
//   master  the byte producer (drives tx_start/tx_data)
//   slave   the transmitter itself (drives txd/tx_busy/tx_done)

interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  txd,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output txd,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter with optional even parity bit.
//
// Parameters:
//   BPS_DR   bit period minus one, in clk cycles (default 5207 -> 9600 baud
//            at 50 MHz).
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   rst_n    asynchronous active-low reset
//   bus      uart_tx_if.slave: tx_start/tx_data in, txd/tx_busy/tx_done out
//
// Configuration:
//   UART_TX_PARITY_EN  when defined, an even-parity bit (XOR of the 8 data
//                      bits) is sent between the last data bit and the stop
//                      bit. When undefined the frame is start + 8 data + stop
//                      and no parity logic exists.
//
// All three outputs come straight from flops, so txd never glitches.

module uart_tx #(
    parameter logic [12:0] BPS_DR = 13'd5207
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_tx_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t      state_q;
    logic [12:0] div_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        txd_q;
    logic        tx_busy_q;
    logic        tx_done_q;
    logic        bit_end;

    // The current bit has been on the line for BPS_DR+1 cycles.
    assign bit_end = (div_q == BPS_DR);

    assign bus.txd     = txd_q;
    assign bus.tx_busy = tx_busy_q;
    assign bus.tx_done = tx_done_q;

    // The latched byte is never shifted; bit_q indexes it directly so the
    // full byte stays available for the parity bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            div_q     <= bit_end ? 13'd0 : div_q + 13'd1;

            case (state_q)
                IDLE: begin
                    div_q <= '0;
                    bit_q <= '0;
                    txd_q <= 1'b1;
                    if (bus.tx_start) begin
                        shift_q   <= bus.tx_data;
                        txd_q     <= 1'b0;
                        tx_busy_q <= 1'b1;
                        state_q   <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        txd_q   <= shift_q[0];
                        bit_q   <= '0;
                        state_q <= DATA;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            txd_q   <= ^shift_q;
                            state_q <= PARITY;
`else
                            txd_q   <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            txd_q <= shift_q[bit_q + 3'd1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        txd_q   <= 1'b1;
                        state_q <= STOP;
                    end
                end
`endif

                STOP: begin
                    // Dropping busy here lets a tx_start held during the
                    // tx_done cycle be accepted with no idle gap.
                    if (bit_end) begin
                        txd_q     <= 1'b1;
                        tx_busy_q <= 1'b0;
                        tx_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end

                default: begin
                    txd_q     <= 1'b1;
                    tx_busy_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule
